// File: rtl/l15_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// l15_port_arbiter_if
// Bundles the OpenPiton L1.5 transducer port (request and response side).
//   master : the arbiter, which drives transducer_l15_* and consumes l15_transducer_*
//   slave  : the L1.5 (or a bench model of it), which does the opposite
// Request side  : transducer_l15_{rqtype,size,address,data,val}
// Accept side   : l15_transducer_{header_ack,ack}
// Response side : l15_transducer_{val,data_0,data_1,returntype}, transducer_l15_req_ack
// ---------------------------------------------------------------------------
interface l15_port_arbiter_if;
    logic [4:0]  transducer_l15_rqtype;
    logic [2:0]  transducer_l15_size;
    logic [31:0] transducer_l15_address;
    logic [63:0] transducer_l15_data;
    logic        transducer_l15_val;
    logic        transducer_l15_req_ack;
    logic        l15_transducer_header_ack;
    logic        l15_transducer_ack;
    logic        l15_transducer_val;
    logic [63:0] l15_transducer_data_0;
    logic [63:0] l15_transducer_data_1;
    logic [3:0]  l15_transducer_returntype;

    modport master (
        output transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
               transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
        input  l15_transducer_header_ack, l15_transducer_ack, l15_transducer_val,
               l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype
    );

    modport slave (
        input  transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
               transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
        output l15_transducer_header_ack, l15_transducer_ack, l15_transducer_val,
               l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype
    );
endinterface

// File: rtl/l15_port_arbiter.sv
// ---------------------------------------------------------------------------
// l15_port_arbiter
// Shares the single L1.5 transducer port between the IFU and the LSU with one
// transaction outstanding at a time. The winning request is latched, driven to
// the L1.5, and the response is routed only to the owner. Unsolicited returns
// are acknowledged and swallowed (INT_RET also pulses int_wake).
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   ifu_val, ifu_addr              IFU fetch request (held until ifu_gnt)
//   lsu_val, lsu_rqtype/size/addr/data  LSU request (held until lsu_gnt)
//   ifu_gnt, lsu_gnt               header-accepted pulses to the owner
//   ifu_resp_val, lsu_resp_val     response-valid pulses to the owner
//   resp_data, resp_rtype          response passthrough
//   int_wake                       pulse on INT_RET
//   arb_owner_lsu                  LSU currently owns the port
//   l15                            L1.5 transducer port (master side)
// ---------------------------------------------------------------------------
module l15_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,   // 1..15
    parameter logic [4:0]  IFU_RQTYPE   = 5'd0,
    parameter logic [2:0]  IFU_SIZE     = 3'd3
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          ifu_val,
    input  logic [31:0]   ifu_addr,
    input  logic          lsu_val,
    input  logic [4:0]    lsu_rqtype,
    input  logic [2:0]    lsu_size,
    input  logic [31:0]   lsu_addr,
    input  logic [63:0]   lsu_data,
    output logic          ifu_gnt,
    output logic          lsu_gnt,
    output logic          ifu_resp_val,
    output logic          lsu_resp_val,
    output logic [127:0]  resp_data,
    output logic [3:0]    resp_rtype,
    output logic          int_wake,
    output logic          arb_owner_lsu,
    l15_port_arbiter_if.master l15
);

    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);
    localparam logic [3:0] RT_LOAD_RET    = 4'b0000;
    localparam logic [3:0] RT_IFILL_RET   = 4'b0001;
    localparam logic [3:0] RT_ST_ACK      = 4'b0100;
    localparam logic [3:0] RT_INT_RET     = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_WACK = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        owner_lsu_r;
    logic [3:0]  starve_cnt_r;
    logic [4:0]  rqtype_r;
    logic [2:0]  size_r;
    logic [31:0] addr_r;
    logic [63:0] data_r;

    logic        arb_fire_s;
    logic        lsu_wins_s;
    logic        fwd_rtype_s;
    logic        resp_done_s;

    // Only these return types complete the outstanding request; everything else
    // is unsolicited traffic from the L1.5.
    function automatic logic is_fwd_rtype(input logic [3:0] rt);
        logic fwd;
        case (rt)
            RT_LOAD_RET, RT_IFILL_RET, RT_ST_ACK: fwd = 1'b1;
            default:                               fwd = 1'b0;
        endcase
        return fwd;
    endfunction

    assign arb_fire_s  = (state_r == ST_IDLE) && (ifu_val || lsu_val);
    // LSU wins ties unless IFU has lost STARVE_LIMIT arbitrations in a row.
    assign lsu_wins_s  = lsu_val && !(ifu_val && (starve_cnt_r == STARVE_LIMIT_C));
    assign fwd_rtype_s = is_fwd_rtype(l15.l15_transducer_returntype);
    assign resp_done_s = (state_r == ST_RESP) && l15.l15_transducer_val && fwd_rtype_s;

    // Response data and type are passed straight through; only the valid is steered.
    assign resp_data  = {l15.l15_transducer_data_1, l15.l15_transducer_data_0};
    assign resp_rtype = l15.l15_transducer_returntype;

    assign l15.transducer_l15_rqtype  = rqtype_r;
    assign l15.transducer_l15_size    = size_r;
    assign l15.transducer_l15_address = addr_r;
    assign l15.transducer_l15_data    = data_r;

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_fire_s) begin
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (l15.l15_transducer_header_ack && l15.l15_transducer_ack) begin
                    state_nxt_s = ST_RESP;
                end else if (l15.l15_transducer_header_ack) begin
                    state_nxt_s = ST_WACK;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_WACK: begin
                if (l15.l15_transducer_ack) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WACK;
                end
            end
            ST_RESP: begin
                if (resp_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Arbitration capture: latch winner, its request fields and the starvation count
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            owner_lsu_r  <= 1'b0;
            starve_cnt_r <= 4'd0;
            rqtype_r     <= 5'd0;
            size_r       <= 3'd0;
            addr_r       <= 32'd0;
            data_r       <= 64'd0;
        end else if (arb_fire_s) begin
            owner_lsu_r <= lsu_wins_s;
            if (lsu_wins_s) begin
                rqtype_r <= lsu_rqtype;
                size_r   <= lsu_size;
                addr_r   <= lsu_addr;
                data_r   <= lsu_data;
                if (ifu_val && (starve_cnt_r != 4'hf)) begin
                    starve_cnt_r <= starve_cnt_r + 4'd1;
                end
            end else begin
                rqtype_r     <= IFU_RQTYPE;
                size_r       <= IFU_SIZE;
                addr_r       <= ifu_addr;
                data_r       <= 64'd0;
                starve_cnt_r <= 4'd0;
            end
        end
    end

    // Output decode from current state, owner and L1.5 handshakes
    always_comb begin
        ifu_gnt                    = 1'b0;
        lsu_gnt                    = 1'b0;
        ifu_resp_val               = 1'b0;
        lsu_resp_val               = 1'b0;
        arb_owner_lsu              = 1'b0;
        l15.transducer_l15_val     = 1'b0;
        // Every response beat is consumed, including unsolicited and stale ones.
        l15.transducer_l15_req_ack = l15.l15_transducer_val;
        int_wake = l15.l15_transducer_val && (l15.l15_transducer_returntype == RT_INT_RET);
        if (state_r != ST_IDLE) begin
            arb_owner_lsu = owner_lsu_r;
        end else begin
            arb_owner_lsu = 1'b0;
        end
        if ((state_r == ST_HDR) && l15.l15_transducer_header_ack) begin
            ifu_gnt = !owner_lsu_r;
            lsu_gnt = owner_lsu_r;
        end else begin
            ifu_gnt = 1'b0;
            lsu_gnt = 1'b0;
        end
        if (resp_done_s) begin
            ifu_resp_val = !owner_lsu_r;
            lsu_resp_val = owner_lsu_r;
        end else begin
            ifu_resp_val = 1'b0;
            lsu_resp_val = 1'b0;
        end
        if (state_r == ST_HDR) begin
            l15.transducer_l15_val = 1'b1;
        end else begin
            l15.transducer_l15_val = 1'b0;
        end
    end

endmodule
